// File: rtl/code_entry_ctrl.sv
// Passcode entry FSM: collects debounced key pulses, checks against CODE on OK, enforces retry lockout.
// Latency: verdict registered one cycle after the ok edge; no backpressure, every input pulse is consumed or dropped.
module code_entry_ctrl #(
  parameter int                     CODE_LEN    = 4,
  parameter logic [2*CODE_LEN-1:0]  CODE        = 8'b01_10_11_01,
  parameter int                     MAX_FAIL    = 3,
  parameter int unsigned            LOCK_CYC    = 250_000_000,
  parameter int unsigned            TIMEOUT_CYC = 500_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key1_p,
  input  logic       key2_p,
  input  logic       key3_p,
  input  logic       ok_p,
  output logic [1:0] result,
  output logic       result_vld,
  output logic [3:0] digit_cnt,
  output logic       locked
);

  localparam int          W        = 2 * CODE_LEN;
  localparam int          FW       = $clog2(MAX_FAIL + 1);
  localparam logic [3:0]  LEN4     = 4'(CODE_LEN);
  localparam logic [FW:0] FAIL_LIM = (FW + 1)'(MAX_FAIL);
  localparam logic [31:0] TO_LAST  = 32'(TIMEOUT_CYC - 1);
  localparam logic [31:0] LK_LAST  = 32'(LOCK_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_ENTRY, S_CHECK, S_LOCK} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   code_q, code_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           ovf_q, ovf_d;
  logic [FW-1:0]  fail_q, fail_d;
  logic [31:0]    tmr_q, tmr_d;
  logic [1:0]     result_q, result_d;
  logic           vld_q, vld_d;
  logic           locked_q, locked_d;

  logic [1:0]     key_n;
  logic           multi, single;
  logic [1:0]     sym;
  logic [W-1:0]   shifted;
  logic [FW:0]    fail_inc;
  logic           match;

  always_comb begin
    key_n    = {1'b0, key1_p} + {1'b0, key2_p} + {1'b0, key3_p};
    multi    = key_n[1];
    single   = (key_n == 2'd1);
    sym      = key1_p ? 2'b01 : (key2_p ? 2'b10 : 2'b11);
    shifted  = (code_q << 2) | W'(sym);
    fail_inc = {1'b0, fail_q} + (FW + 1)'(1);
    match    = (cnt_q == LEN4) && !ovf_q && (code_q == CODE);
  end

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    fail_d   = fail_q;
    tmr_d    = tmr_q;
    result_d = result_q;
    vld_d    = 1'b0;
    locked_d = locked_q;
    case (state_q)
      S_IDLE: begin
        if (multi) begin
          state_d  = S_ENTRY;
          cnt_d    = 4'd0;
          ovf_d    = 1'b1;
          result_d = 2'b00;
          tmr_d    = 32'd0;
        end else if (single) begin
          state_d  = S_ENTRY;
          code_d   = W'(sym);
          cnt_d    = 4'd1;
          ovf_d    = 1'b0;
          result_d = 2'b00;
          tmr_d    = 32'd0;
        end
      end
      S_ENTRY: begin
        // ok wins over any key in the same cycle; that key is dropped
        if (ok_p) begin
          state_d = S_CHECK;
          tmr_d   = 32'd0;
        end else if (multi || single) begin
          tmr_d = 32'd0;
          if (multi || cnt_q == LEN4) begin
            ovf_d = 1'b1;
          end else begin
            code_d = shifted;
            cnt_d  = cnt_q + 4'd1;
          end
        end else if (tmr_q == TO_LAST) begin
          state_d = S_IDLE;
          code_d  = '0;
          cnt_d   = 4'd0;
          ovf_d   = 1'b0;
          tmr_d   = 32'd0;
        end else begin
          tmr_d = tmr_q + 32'd1;
        end
      end
      S_CHECK: begin
        vld_d   = 1'b1;
        code_d  = '0;
        cnt_d   = 4'd0;
        ovf_d   = 1'b0;
        state_d = S_IDLE;
        if (match) begin
          result_d = 2'b01;
          fail_d   = '0;
        end else if (fail_inc < FAIL_LIM) begin
          result_d = 2'b10;
          fail_d   = fail_q + FW'(1);
        end else begin
          result_d = 2'b11;
          locked_d = 1'b1;
          tmr_d    = 32'd0;
          state_d  = S_LOCK;
        end
      end
      S_LOCK: begin
        // Exit on the edge after the timer reaches its last value: LOCK_CYC cycles total
        if (tmr_q == LK_LAST) begin
          state_d  = S_IDLE;
          result_d = 2'b00;
          locked_d = 1'b0;
          fail_d   = '0;
          tmr_d    = 32'd0;
        end else begin
          tmr_d = tmr_q + 32'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      code_q   <= '0;
      cnt_q    <= 4'd0;
      ovf_q    <= 1'b0;
      fail_q   <= '0;
      tmr_q    <= 32'd0;
      result_q <= 2'b00;
      vld_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      fail_q   <= fail_d;
      tmr_q    <= tmr_d;
      result_q <= result_d;
      vld_q    <= vld_d;
      locked_q <= locked_d;
    end
  end

  assign result     = result_q;
  assign result_vld = vld_q;
  assign digit_cnt  = cnt_q;
  assign locked     = locked_q;

endmodule

// File: tb/tb_code_entry_ctrl.sv
// Directed bench for code_entry_ctrl: cycle-by-cycle vector table plus hand sequences for timeout and reset.
// Runs with LOCK_CYC=20, TIMEOUT_CYC=50.
module tb_code_entry_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key1_p = 1'b0, key2_p = 1'b0, key3_p = 1'b0, ok_p = 1'b0;
  logic [1:0] result;
  logic       result_vld;
  logic [3:0] digit_cnt;
  logic       locked;

  int errors = 0;
  int checks = 0;

  code_entry_ctrl #(.LOCK_CYC(20), .TIMEOUT_CYC(50)) dut (
    .clk(clk), .rst_n(rst_n),
    .key1_p(key1_p), .key2_p(key2_p), .key3_p(key3_p), .ok_p(ok_p),
    .result(result), .result_vld(result_vld), .digit_cnt(digit_cnt), .locked(locked)
  );

  always #5 clk = ~clk;

  localparam logic [3:0] N  = 4'b0000;
  localparam logic [3:0] K1 = 4'b1000;
  localparam logic [3:0] K2 = 4'b0100;
  localparam logic [3:0] K3 = 4'b0010;
  localparam logic [3:0] OK = 4'b0001;

  typedef struct {
    logic [3:0] in;
    logic [1:0] res;
    logic       vld;
    logic [3:0] cnt;
    logic       lck;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic [3:0] in, logic [1:0] res, logic vld, logic [3:0] cnt, logic lck);
    vec_t v;
    v.in = in; v.res = res; v.vld = vld; v.cnt = cnt; v.lck = lck;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] r, input logic v, input logic [3:0] c, input logic l);
    chk($sformatf("%s result", tag), 32'(result), 32'(r));
    chk($sformatf("%s result_vld", tag), 32'(result_vld), 32'(v));
    chk($sformatf("%s digit_cnt", tag), 32'(digit_cnt), 32'(c));
    chk($sformatf("%s locked", tag), 32'(locked), 32'(l));
  endtask

  task automatic set_in(input logic [3:0] in);
    {key1_p, key2_p, key3_p, ok_p} = in;
  endtask

  // Apply inputs for one edge, then sample 1 time unit after it.
  task automatic drive(input logic [3:0] in);
    set_in(in);
    @(posedge clk);
    #1;
    set_in(N);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(N);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    #12;
    chk_all("reset", 2'b00, 1'b0, 4'd0, 1'b0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // correct code
    add(K1, 0, 0, 1, 0); add(K2, 0, 0, 2, 0); add(K3, 0, 0, 3, 0); add(K1, 0, 0, 4, 0);
    add(OK, 0, 0, 4, 0); add(N, 1, 1, 0, 0); add(N, 1, 0, 0, 0);
    // ok alone in IDLE is ignored
    add(OK, 1, 0, 0, 0); add(N, 1, 0, 0, 0);
    // wrong last digit
    add(K1, 0, 0, 1, 0); add(K2, 0, 0, 2, 0); add(K3, 0, 0, 3, 0); add(K2, 0, 0, 4, 0);
    add(OK, 0, 0, 4, 0); add(N, 2, 1, 0, 0); add(N, 2, 0, 0, 0);
    // short entry
    add(K1, 0, 0, 1, 0); add(K2, 0, 0, 2, 0); add(OK, 0, 0, 2, 0);
    add(N, 2, 1, 0, 0); add(N, 2, 0, 0, 0);
    // five digits: fifth saturates, third fail locks
    add(K1, 0, 0, 1, 0); add(K2, 0, 0, 2, 0); add(K3, 0, 0, 3, 0); add(K1, 0, 0, 4, 0);
    add(K2, 0, 0, 4, 0); add(OK, 0, 0, 4, 0); add(N, 3, 1, 0, 1);
    // correct code during lock ignored; lock lasts exactly 20 edges
    add(K1, 3, 0, 0, 1); add(K2, 3, 0, 0, 1); add(K3, 3, 0, 0, 1); add(K1, 3, 0, 0, 1);
    add(OK, 3, 0, 0, 1);
    for (int i = 0; i < 14; i++) add(N, 3, 0, 0, 1);
    add(N, 0, 0, 0, 0);
    // pass after lock exit
    add(K1, 0, 0, 1, 0); add(K2, 0, 0, 2, 0); add(K3, 0, 0, 3, 0); add(K1, 0, 0, 4, 0);
    add(OK, 0, 0, 4, 0); add(N, 1, 1, 0, 0); add(N, 1, 0, 0, 0);
    // two keys at once, then otherwise-correct code
    add(K1 | K2, 0, 0, 0, 0);
    add(K1, 0, 0, 1, 0); add(K2, 0, 0, 2, 0); add(K3, 0, 0, 3, 0); add(K1, 0, 0, 4, 0);
    add(OK, 0, 0, 4, 0); add(N, 2, 1, 0, 0); add(N, 2, 0, 0, 0);
    // last digit together with ok is discarded
    add(K1, 0, 0, 1, 0); add(K2, 0, 0, 2, 0); add(K3, 0, 0, 3, 0);
    add(K1 | OK, 0, 0, 3, 0); add(N, 2, 1, 0, 0); add(N, 2, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].in);
      chk_all($sformatf("row%0d", i), tbl[i].res, tbl[i].vld, tbl[i].cnt, tbl[i].lck);
    end

    // Timeout: key at E0, still entering after E49, back to IDLE after E50 (fail count now 2)
    drive(K1);
    chk_all("to_start", 2'b00, 1'b0, 4'd1, 1'b0);
    idle(49);
    chk_all("to_49", 2'b00, 1'b0, 4'd1, 1'b0);
    idle(1);
    chk_all("to_50", 2'b00, 1'b0, 4'd0, 1'b0);

    // Fail count survived the timeout: one more wrong entry locks
    drive(K1); drive(K2); drive(K3); drive(K2); drive(OK); drive(N);
    chk_all("to_keeps_fail", 2'b11, 1'b1, 4'd0, 1'b1);
    idle(5);
    chk_all("lock_mid", 2'b11, 1'b0, 4'd0, 1'b1);

    // Async reset during LOCK
    #2 rst_n = 1'b0;
    #1 chk_all("rst_lock", 2'b00, 1'b0, 4'd0, 1'b0);
    @(posedge clk);
    #1 chk_all("rst_lock_hold", 2'b00, 1'b0, 4'd0, 1'b0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1 chk_all("rst_lock_rel", 2'b00, 1'b0, 4'd0, 1'b0);

    // Async reset during ENTRY with three digits
    drive(K1); drive(K2); drive(K3);
    chk_all("entry3", 2'b00, 1'b0, 4'd3, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_all("rst_entry", 2'b00, 1'b0, 4'd0, 1'b0);
    @(posedge clk);
    #1;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1 chk_all("rst_entry_rel", 2'b00, 1'b0, 4'd0, 1'b0);

    // Reset cleared the fail count: a wrong entry is a plain fail, then a pass
    drive(K1); drive(OK); drive(N);
    chk_all("post_rst_fail", 2'b10, 1'b1, 4'd0, 1'b0);
    drive(K1); drive(K2); drive(K3); drive(K1); drive(OK); drive(N);
    chk_all("post_rst_pass", 2'b01, 1'b1, 4'd0, 1'b0);
    drive(N);
    chk_all("post_rst_hold", 2'b01, 1'b0, 4'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/code_entry_ctrl.md
# code_entry_ctrl

Passcode entry controller for the electronic lock. It sits between the four key debouncers and the LED indication stage. It collects debounced key pulses into a digit sequence and compares the sequence against a parameterised code when OK is pressed. It drives a 2-bit verdict level to the LED stage and enforces a retry limit with a timed lockout.

## Interface
- CODE_LEN, 4: number of digits in the code (1..8).
- CODE, 8'b01_10_11_01: expected code, 2 bits per digit. Key1=2'b01, key2=2'b10, key3=2'b11. The first digit is in the MSBs. Width is 2*CODE_LEN.
- MAX_FAIL, 3: consecutive failed attempts that trigger lockout (≥1).
- LOCK_CYC, 250_000_000: lockout duration in clk cycles.
- TIMEOUT_CYC, 500_000_000: inactivity timeout during entry, in clk cycles.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- key1_p  in  1  single-cycle pulse, digit 1 pressed (debounced).
- key2_p  in  1  single-cycle pulse, digit 2 pressed.
- key3_p  in  1  single-cycle pulse, digit 3 pressed.
- ok_p  in  1  single-cycle pulse, confirm pressed.
- result  out  2  verdict level: 00 idle/entering, 01 pass, 10 fail, 11 locked.
- result_vld  out  1  one-cycle pulse on every verdict update (01/10/11).
- digit_cnt  out  4  digits accepted in the current entry (0..CODE_LEN, saturating).
- locked  out  1  high while in LOCK.

## Operation
States: IDLE, ENTRY, CHECK, LOCK.

- **Reset values:** state IDLE; result=00; result_vld=0; digit_cnt=0; locked=0; fail counter=0; digit buffer=0; overflow flag=0; timers=0.

**IDLE**
- result holds its last verdict.
- A single key pulse stores its symbol, sets digit_cnt=1, clears result to 00, and moves to ENTRY.
- ok_p alone is ignored.

**ENTRY**
- Each single key pulse shifts the 2-bit symbol into the buffer LSBs (older digits move up) and increments digit_cnt.
- A key pulse with digit_cnt==CODE_LEN sets the overflow flag. The buffer and digit_cnt are unchanged.
- Two or more key pulses in the same cycle set the overflow flag; nothing is stored.
- ok_p moves to CHECK. A key pulse in the same cycle as ok_p is discarded.
- The inactivity timer resets on any key or ok pulse. When it reaches TIMEOUT_CYC-1:
  - buffer, digit_cnt and overflow flag are cleared;
  - state returns to IDLE;
  - result stays 00 and the fail counter is unchanged.

**IDLE, two or more simultaneous key pulses**
- The same rule as ENTRY applies: the state enters ENTRY with digit_cnt=0 and the overflow flag set.

**CHECK (1 cycle)**
- Match condition: digit_cnt==CODE_LEN, overflow flag clear, and buffer==CODE.
- On a match:
  - result=01;
  - fail counter=0;
  - next state IDLE.
- On a mismatch with fail counter+1 < MAX_FAIL:
  - fail counter increments;
  - result=10;
  - next state IDLE.
- On a mismatch with fail counter+1 == MAX_FAIL:
  - result=11;
  - locked=1;
  - lock timer=0;
  - next state LOCK.
- In every case, result_vld=1 for this update, and buffer, digit_cnt and overflow flag are cleared.

**LOCK**
- All key and ok pulses are ignored.
- The lock timer counts up to LOCK_CYC-1. On the following edge:
  - state returns to IDLE;
  - result=00;
  - locked=0;
  - fail counter=0.
- result_vld stays 0 on lock exit.

Other rules:
- Fail counter width is clog2(MAX_FAIL+1). It is cleared only by a pass or a lock exit, never by a timeout.
- Timers are 32-bit unsigned.

## Timing
- Key pulse at edge N: digit_cnt is updated and visible after edge N.
- ok_p at edge N: the state is CHECK after edge N. result and result_vld are registered at edge N+1, so the verdict is visible one cycle after the ok edge. result_vld is high for exactly that one cycle.
- result is a held level between updates, so the LED stage may sample it at any time.
- Lockout lasts exactly LOCK_CYC cycles from the edge at which locked rises to the edge at which it falls.
- Asynchronous reset mid-entry or mid-lockout forces all reset values immediately. No verdict pulse is produced.

## Test plan
Run with LOCK_CYC=20 and TIMEOUT_CYC=50; other parameters at their defaults.

1. **Pass:** pulses key1, key2, key3, key1, then ok → one cycle after ok, result=01 and result_vld=1 for 1 cycle; afterwards digit_cnt=0 and the fail counter is 0.
2. **Wrong code and short entry:** key1,key2,key3,key2 then ok → result=10. Then key1,key2 then ok → result=10. Then key pulses with 5 digits → the 5th digit leaves digit_cnt at 4; ok → result=11 (third fail), locked=1.
3. **Lockout:** continue from test 2 and press the correct code during LOCK → ignored. locked stays high exactly 20 cycles, then result=00 and locked=0; a correct code now gives result=01.
4. **Timeout:** key1, then idle 50 cycles → digit_cnt=0, state IDLE, result=00. A following correct entry passes; the fail count is unaffected.
5. **Simultaneous events:**
   - key1_p and key2_p in the same cycle, followed by an otherwise correct code → result=10.
   - The last digit asserted together with ok_p → that digit is discarded, so result=10.
6. **Reset:** assert rst_n low during ENTRY with digit_cnt=3, and again during LOCK → all outputs take reset values at once. No result_vld pulse occurs.
